// File: rtl/onn_ctrl_pkg.sv
// ============================================================================
// Module : onn_ctrl_pkg
// Brief  : Shared types and defaults for the ONN neuron control block.
//          Averaging defaults exist only when PHASE_AVG_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package onn_ctrl_pkg;

  localparam int CW_DEFAULT = 8;

`ifdef PHASE_AVG_EN
  localparam int AVG_N_DEFAULT = 4;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/neuron_phase_meter_if.sv
// ============================================================================
// Module : neuron_phase_meter_if
// Brief  : Edge-pulse inputs and phase/period result bus of the phase meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface neuron_phase_meter_if
  import onn_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
);

  logic          ref_edge;
  logic          nrn_edge;
  logic [CW-1:0] phase;
  logic [CW-1:0] period;
  logic          valid;
  logic          miss;
  logic          ovf;

  modport master (
    output ref_edge, nrn_edge,
    input  phase, period, valid, miss, ovf
  );

  modport slave (
    input  ref_edge, nrn_edge,
    output phase, period, valid, miss, ovf
  );

endinterface

`default_nettype wire

// File: rtl/phase_avg.sv
// ============================================================================
// Module : phase_avg
// Brief  : Accumulates AVG_N phase/period samples and publishes their mean.
//          Built only when PHASE_AVG_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module phase_avg #(
  parameter int CW    = 8,
  parameter int AVG_N = 4
) (
  input  logic          clk,
  input  logic          re,
  input  logic          clr,
  input  logic          sample,
  input  logic [CW-1:0] phase_in,
  input  logic [CW-1:0] period_in,
  output logic [CW-1:0] phase,
  output logic [CW-1:0] period,
  output logic          valid
);

  localparam int SH = $clog2(AVG_N);
  localparam int AW = CW + SH;
  localparam int NW = (SH > 0) ? SH : 1;
  localparam logic [NW-1:0] LAST = NW'(AVG_N - 1);

  logic [AW-1:0] acc_ph;
  logic [AW-1:0] acc_pd;
  logic [AW-1:0] sum_ph;
  logic [AW-1:0] sum_pd;
  logic [NW-1:0] n;

  assign sum_ph = acc_ph + AW'(phase_in);
  assign sum_pd = acc_pd + AW'(period_in);

  always_ff @(posedge clk) begin
    if (re) begin
      acc_ph <= '0;
      acc_pd <= '0;
      n      <= '0;
      phase  <= '0;
      period <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        acc_ph <= '0;
        acc_pd <= '0;
        n      <= '0;
      end else if (sample) begin
        if (n == LAST) begin
          // Power-of-two AVG_N makes the mean a plain truncating shift.
          phase  <= sum_ph[SH +: CW];
          period <= sum_pd[SH +: CW];
          valid  <= 1'b1;
          acc_ph <= '0;
          acc_pd <= '0;
          n      <= '0;
        end else begin
          acc_ph <= sum_ph;
          acc_pd <= sum_pd;
          n      <= n + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_phase_meter.sv
// ============================================================================
// Module : neuron_phase_meter
// Brief  : Measures neuron phase offset and reference period from pef edge
//          pulses. Optional averaging enabled by macro PHASE_AVG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module neuron_phase_meter
  import onn_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
`ifdef PHASE_AVG_EN
  , parameter int AVG_N = AVG_N_DEFAULT
`endif
) (
  input  logic                clk,
  input  logic                re,
  neuron_phase_meter_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ph_reg;
  logic          captured;
  logic          miss_q;
  logic          ovf_q;

  logic [CW-1:0] phase_q;
  logic [CW-1:0] period_q;
  logic          valid_q;

  logic close_ok;
  logic close_miss;
  logic sat;

  assign close_ok   = (state == ST_MEAS) && bus.ref_edge && captured;
  assign close_miss = (state == ST_MEAS) && bus.ref_edge && !captured;
  assign sat        = (state == ST_MEAS) && !bus.ref_edge && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (re) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ph_reg   <= '0;
      captured <= 1'b0;
      miss_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      miss_q <= close_miss;
      case (state)
        ST_IDLE: begin
          if (bus.ref_edge) begin
            state    <= ST_MEAS;
            cnt      <= CW'(1);
            ph_reg   <= '0;
            captured <= bus.nrn_edge;
          end
        end
        ST_MEAS: begin
          if (bus.ref_edge) begin
            // A coincident neuron edge opens the new period at phase 0.
            cnt      <= CW'(1);
            ph_reg   <= '0;
            captured <= bus.nrn_edge;
          end else if (sat) begin
            ovf_q    <= 1'b1;
            state    <= ST_IDLE;
            captured <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (bus.nrn_edge && !captured) begin
              ph_reg   <= cnt;
              captured <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PHASE_AVG_EN
  phase_avg #(
    .CW    (CW),
    .AVG_N (AVG_N)
  ) u_phase_avg (
    .clk       (clk),
    .re        (re),
    .clr       (close_miss | sat),
    .sample    (close_ok),
    .phase_in  (ph_reg),
    .period_in (cnt),
    .phase     (phase_q),
    .period    (period_q),
    .valid     (valid_q)
  );
`else
  always_ff @(posedge clk) begin
    if (re) begin
      phase_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= close_ok;
      if (close_ok) begin
        phase_q  <= ph_reg;
        period_q <= cnt;
      end
    end
  end
`endif

  assign bus.phase  = phase_q;
  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.miss   = miss_q;
  assign bus.ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_phase_meter.sv
// ============================================================================
// Module : tb_neuron_phase_meter
// Brief  : Scoreboard bench for neuron_phase_meter (raw or PHASE_AVG_EN build).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_neuron_phase_meter;
  import onn_ctrl_pkg::*;

  localparam int CW = 8;
`ifdef PHASE_AVG_EN
  localparam int AVG = 4;
`endif

  typedef struct {
    bit         miss;
    logic [7:0] ph;
    logic [7:0] pd;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic re;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  exp_t sb[$];
  int   offs[8];

  logic [7:0] held_ph, held_pd;
  int         acc_ph, acc_pd, acc_n;

  neuron_phase_meter_if #(.CW(CW)) bus ();

  neuron_phase_meter #(.CW(CW)) dut (
    .clk (clk),
    .re  (re),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every valid/miss must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid === 1'b1 || bus.miss === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: valid=%0b miss=%0b phase=%0d period=%0d cycle=%0d, required no strobe",
                 bus.valid, bus.miss, bus.phase, bus.period, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.valid !== !e.miss || bus.miss !== e.miss || bus.phase !== e.ph ||
            bus.period !== e.pd || cyc != e.due) begin
          tests_failed++;
          $display("FAIL strobe: got valid=%0b miss=%0b phase=%0d period=%0d cycle=%0d, required valid=%0b miss=%0b phase=%0d period=%0d cycle=%0d",
                   bus.valid, bus.miss, bus.phase, bus.period, cyc,
                   !e.miss, e.miss, e.ph, e.pd, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input bit r, input bit n);
    bus.ref_edge = r;
    bus.nrn_edge = n;
    @(posedge clk);
    #1;
    bus.ref_edge = 1'b0;
    bus.nrn_edge = 1'b0;
  endtask

  task automatic model_clear();
    acc_ph = 0;
    acc_pd = 0;
    acc_n  = 0;
  endtask

  task automatic do_reset(input int n);
    re = 1'b1;
    repeat (n) tick(1'b0, 1'b0);
    re = 1'b0;
    held_ph = '0;
    held_pd = '0;
    model_clear();
    sb.delete();
  endtask

  task automatic push(input bit m);
    exp_t e;
    e.miss = m;
    e.ph   = held_ph;
    e.pd   = held_pd;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Expected outcome of a period closed by the ref edge about to be driven.
  task automatic model_close(input bit cap, input int ph, input int pd);
    if (!cap) begin
      push(1'b1);
      model_clear();
    end else begin
`ifdef PHASE_AVG_EN
      acc_ph += ph;
      acc_pd += pd;
      acc_n++;
      if (acc_n == AVG) begin
        held_ph = 8'(acc_ph / AVG);
        held_pd = 8'(acc_pd / AVG);
        push(1'b0);
        model_clear();
      end
`else
      held_ph = 8'(ph);
      held_pd = 8'(pd);
      push(1'b0);
`endif
    end
  endtask

  // np periods of length per; offs[i] is the neuron offset in period i (-1 = none).
  task automatic run_train(input int per, input int np);
    for (int i = 0; i <= np; i++) begin
      if (i > 0) model_close(offs[i-1] >= 0, offs[i-1], per);
      tick(1'b1, (i < np) && (offs[i] == 0));
      if (i < np)
        for (int j = 1; j < per; j++) tick(1'b0, offs[i] == j);
    end
    repeat (3) tick(1'b0, 1'b0);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drained: %0d strobes still pending, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset(3);
    repeat (4) tick(1'b0, 1'b0);
    tests_run++;
    if (bus.phase !== 8'd0) begin tests_failed++; $display("FAIL reset_phase: got %0d required 0", bus.phase); end
    tests_run++;
    if (bus.period !== 8'd0) begin tests_failed++; $display("FAIL reset_period: got %0d required 0", bus.period); end
    tests_run++;
    if (bus.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b required 0", bus.valid); end
    tests_run++;
    if (bus.miss !== 1'b0) begin tests_failed++; $display("FAIL reset_miss: got %0b required 0", bus.miss); end
    tests_run++;
    if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b required 0", bus.ovf); end
    tests_run++;
    if (dut.state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d required %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    do_reset(1);
    repeat (25) tick(1'b0, 1'b0);
    tests_run++;
    if (dut.state !== ST_IDLE) begin tests_failed++; $display("FAIL midreset_state: got %0d required %0d", dut.state, ST_IDLE); end
    check_drained("midreset");
  endtask

  task automatic check_held(input string name, input logic [7:0] ph, input logic [7:0] pd);
    tests_run++;
    if (bus.phase !== ph || bus.period !== pd) begin
      tests_failed++;
      $display("FAIL %s_held: got phase=%0d period=%0d required phase=%0d period=%0d",
               name, bus.phase, bus.period, ph, pd);
    end
  endtask

  task automatic test_periodic();
    do_reset(2);
    offs = '{5, 5, 5, 5, 0, 0, 0, 0};
    run_train(20, 4);
    check_drained("periodic");
    check_held("periodic", 8'd5, 8'd20);
  endtask

  task automatic test_coincident();
    do_reset(2);
    offs = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_train(16, 4);
    check_drained("coincident");
    check_held("coincident", 8'd0, 8'd16);
  endtask

  task automatic test_miss();
    do_reset(2);
    offs = '{5, 5, -1, 5, 5, 5, 5, 0};
    run_train(20, 7);
    check_drained("miss");
    check_held("miss", 8'd5, 8'd20);
  endtask

  task automatic test_ovf();
    do_reset(2);
    tick(1'b1, 1'b0);
    repeat (254) tick(1'b0, 1'b0);
    tests_run++;
    if (bus.ovf !== 1'b0 || dut.state !== ST_MEAS) begin
      tests_failed++;
      $display("FAIL ovf_early: got ovf=%0b state=%0d required ovf=0 state=%0d", bus.ovf, dut.state, ST_MEAS);
    end
    tick(1'b0, 1'b0);
    model_clear();
    tests_run++;
    if (bus.ovf !== 1'b1 || dut.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL ovf_set: got ovf=%0b state=%0d required ovf=1 state=%0d", bus.ovf, dut.state, ST_IDLE);
    end
    tick(1'b1, 1'b0);
    repeat (9) tick(1'b0, 1'b0);
    model_close(1'b0, 0, 10);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tests_run++;
    if (bus.ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0b required 1", bus.ovf); end
    check_drained("ovf");
    do_reset(1);
    tests_run++;
    if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %0b required 0", bus.ovf); end
  endtask

`ifdef PHASE_AVG_EN
  task automatic test_avg();
    do_reset(2);
    offs = '{4, 5, 6, 7, 0, 0, 0, 0};
    run_train(20, 4);
    check_drained("avg");
    check_held("avg", 8'd5, 8'd20);
  endtask
`endif

  initial begin
    re = 1'b1;
    bus.ref_edge = 1'b0;
    bus.nrn_edge = 1'b0;
    held_ph = '0;
    held_pd = '0;
    model_clear();
    test_reset();
    test_reset_mid();
    test_periodic();
    test_coincident();
    test_miss();
    test_ovf();
`ifdef PHASE_AVG_EN
    test_avg();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
